// File: rtl/riscv_pkg.sv
// Shared TP2 core definitions used by the writeback stage.
// Contents: instruction-type codes, writeback source select codes, load funct3 codes and the
// writeback FSM state type.
package riscv_pkg;

  localparam logic [3:0] R_TYPE = 4'd0;
  localparam logic [3:0] I_TYPE = 4'd1;
  localparam logic [3:0] S_TYPE = 4'd2;
  localparam logic [3:0] B_TYPE = 4'd3;
  localparam logic [3:0] U_TYPE = 4'd4;
  localparam logic [3:0] J_TYPE = 4'd5;
  localparam logic [3:0] N_TYPE = 4'd7;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StWaitMem,
    StWrite
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback bus: execute handshake and instruction fields, data-memory read return, and the
// register-file write port with retire/error pulses.
// Modports: master = execute/memory/register-file side, slave = writeback_unit.
interface writeback_unit_if;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  instr_type;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_done;
  logic        wb_err;

  modport master (
    output in_valid, instr_type, wb_sel, funct3, rd, alu_result, pc, mem_rdata, mem_rvalid,
    input  in_ready, rf_we, rf_waddr, rf_wdata, wb_done, wb_err
  );

  modport slave (
    input  in_valid, instr_type, wb_sel, funct3, rd, alu_result, pc, mem_rdata, mem_rvalid,
    output in_ready, rf_we, rf_waddr, rf_wdata, wb_done, wb_err
  );

endinterface

// File: rtl/load_extend.sv
// Sub-word load extraction and extension (combinational).
// Ports: word (32-bit memory word), funct3 (load size code), addr (low address bits),
//        value (extended 32-bit result). LW and unknown codes pass the full word.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    unique case (addr)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    // Halfword lane is chosen by addr[1] only; misaligned bit 0 is ignored.
    half_v = addr[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   value = {{24{byte_v[7]}}, byte_v};
      F3_LH:   value = {{16{half_v[15]}}, half_v};
      F3_LBU:  value = {24'd0, byte_v};
      F3_LHU:  value = {16'd0, half_v};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write stage: accepts one retiring instruction, selects ALU result, load data
// or PC+4, waits for data memory on loads (watchdog bounded by TIMEOUT) and issues one write.
// Ports: clk, rst_n (synchronous, active low), bus (writeback_unit_if.slave).
// Parameter: TIMEOUT (1..255) cycles allowed in the memory wait before abort.
// Macro: WB_LOAD_EXT_EN enables sub-word load extraction/extension via load_extend;
//        without it every load writes the full memory word.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst_n,
  writeback_unit_if.slave bus
);

  // Expiry compares against TIMEOUT-1 so the error lands TIMEOUT edges after accept.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  wb_state_e   state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] load_val;
  logic        accept;

  assign accept = (state_q == StIdle) && bus.in_valid;

`ifdef WB_LOAD_EXT_EN
  logic [2:0] funct3_q;
  logic [1:0] addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      funct3_q <= '0;
      addr_q   <= '0;
    end else if (accept) begin
      funct3_q <= bus.funct3;
      addr_q   <= bus.alu_result[1:0];
    end
  end

  load_extend u_load_extend (
    .word   (bus.mem_rdata),
    .funct3 (funct3_q),
    .addr   (addr_q),
    .value  (load_val)
  );
`else
  logic unused_funct3;
  assign unused_funct3 = ^bus.funct3;
  assign load_val      = bus.mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rd_d    = rd_q;
    we_d    = we_q;
    data_d  = data_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          rd_d   = bus.rd;
          we_d   = !(bus.instr_type == S_TYPE || bus.instr_type == B_TYPE ||
                     bus.instr_type == N_TYPE) &&
                   (bus.wb_sel != WB_NONE) && (bus.rd != 5'd0);
          data_d = (bus.wb_sel == WB_PC4) ? bus.pc + 32'd4 : bus.alu_result;
          if (bus.wb_sel == WB_MEM) begin
            state_d = StWaitMem;
            timer_d = '0;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWaitMem: begin
        // Data arriving on the expiry cycle takes priority over the timeout.
        if (bus.mem_rvalid) begin
          data_d  = load_val;
          state_d = StWrite;
        end else if (timer_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready = (state_q == StIdle);
  assign bus.wb_done  = (state_q == StWrite);
  assign bus.rf_we    = (state_q == StWrite) && we_q;
  assign bus.rf_waddr = (state_q == StWrite) ? rd_q : '0;
  assign bus.rf_wdata = (state_q == StWrite) ? data_q : '0;
  assign bus.wb_err   = err_q;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Register-file write stage of the TP2 RISC-V core: the other end of the register-file path whose read data feeds ALU operand construction. It accepts one retiring instruction per handshake from execute, selects the destination value (ALU result, load data or PC+4), waits on data memory for loads, and issues exactly one write strobe toward the register file. Loads are time-bounded by a watchdog counter.

## Interface
- `TIMEOUT`, default 15: max cycles spent in WAIT_MEM before abort; legal 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: execute presents a retiring instruction.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `instr_type` in 4: encoding R=0, I=1, S=2, B=3, U=4, J=5, N=7.
- `wb_sel` in 2: 0=ALU, 1=MEM, 2=PC4, 3=none.
- `funct3` in 3: load size code (LB=0, LH=1, LW=2, LBU=4, LHU=5).
- `rd` in 5: destination register.
- `alu_result` in 32: ALU output; also the load address.
- `pc` in 32: PC of the instruction.
- `mem_rdata` in 32: data memory read word.
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `rf_we` out 1: register-file write strobe.
- `rf_waddr` out 5: write address.
- `rf_wdata` out 32: write data.
- `wb_done` out 1: one-cycle retire pulse.
- `wb_err` out 1: one-cycle load-timeout pulse.

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- IDLE: accept when `in_valid & in_ready`; capture `rd`, `wb_sel`, `funct3`, `alu_result`, `pc`.
  - `wb_sel`=MEM: go WAIT_MEM and clear timer.
  - Otherwise: go WRITE.
- Write-enable qualifier is cleared at accept when `instr_type` is S, B or N, when `wb_sel`=3, or when `rd`=0.
- WAIT_MEM:
  - On `mem_rvalid`: latch the extended `mem_rdata` and go WRITE.
  - Else increment timer. When timer reaches `TIMEOUT`: pulse `wb_err`, go IDLE, no write, no `wb_done`.
  - `mem_rvalid` in the same cycle as expiry: data wins, no error.
- WRITE, one cycle:
  - `rf_we` equals the qualifier.
  - `rf_waddr` is the captured `rd`.
  - `rf_wdata` is the ALU result, the extended load value, or `pc`+32'd4 (mod 2^32).
  - `wb_done`=1; next state IDLE.
- `mem_rvalid` outside WAIT_MEM is ignored.
- `in_valid` while `in_ready`=0 is not accepted; execute must hold it.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE, timer 0. All outputs 0 except `in_ready`=1 from the next cycle. Reset mid-WAIT_MEM or mid-WRITE aborts with no write.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- ALU/PC4 latency: accept at edge N, `rf_we`/`wb_done` high during cycle N+1, `in_ready` high again cycle N+2.
- Load latency: accept at N, `mem_rvalid` sampled at edge N+k (k≥1), write during cycle N+k+1.
- Timeout: `wb_err` is high during cycle N+`TIMEOUT`+1.
- Throughput: at most one retire per 2 cycles.

## Configuration
- `WB_LOAD_EXT_EN` defined: sub-word loads are extracted and extended.
  - Byte lane = `alu_result[1:0]`; half lane = `alu_result[1]`, bit 0 ignored.
  - LB/LH sign-extend, LBU/LHU zero-extend.
  - LW or any other `funct3` passes the full word.
- Undefined: `funct3` is ignored and every load writes the full `mem_rdata`.

## Structure
- Shared package `riscv_pkg` holds:
  - `instr_type` constants (R_TYPE..N_TYPE);
  - `wb_sel` encodings;
  - load `funct3` codes;
  - FSM state typedef.
- One sub-module, `load_extend` (combinational: word, funct3, addr[1:0] -> 32-bit value), instantiated only under `WB_LOAD_EXT_EN`.

## Test plan
- ALU write: R-type, `wb_sel`=0, `rd`=5, `alu_result`=0x0000_00AB -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xAB, `wb_done`=1.
- JAL link: J-type, `wb_sel`=2, `pc`=0xFFFF_FFFC, `rd`=1 -> `rf_wdata`=0x0000_0000 (wrap).
- x0/store suppression: `rd`=0 with `wb_sel`=0, then S-type with `rd`=3 -> `wb_done`=1 both times, `rf_we`=0 both times.
- Load with wait: LB, addr 0x1001, `mem_rdata`=0x0000_8000, `mem_rvalid` after 3 cycles:
  - with macro -> `rf_wdata`=0xFFFF_FF80;
  - without macro -> `rf_wdata`=0x0000_8000.
- Timeout: load accepted, `mem_rvalid` never asserted, `TIMEOUT`=15 -> `wb_err` pulse in cycle 16 after accept, no `rf_we`, `in_ready`=1 next cycle. `mem_rvalid` exactly at expiry -> write, no `wb_err`.
- Reset mid-load: `rst_n`=0 while in WAIT_MEM -> next cycle all outputs 0. A later `mem_rvalid` causes no write.
